mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access stage directly downstream of the execute ALU. It takes the ALU result (effective address for LOAD/STORE, or the final value for every other opcode) plus the rs2 store data. It performs aligned byte/half/word accesses on a single-outstanding data-memory request/ready interface, with byte-lane steering and load sign/zero extension. The registered result goes to writeback, and the stage back-pressures execute while a memory access is in flight.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
MEM_TIMEOUT, 255, max cycles waiting for mem_ready before a bus error is raised; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
ex_valid  in  1  execute presents an instruction this cycle
ex_ready  out  1  stage accepts the instruction; a transfer occurs when ex_valid && ex_ready
ex_instr  in  32  instruction word; opcode is [6:0] and funct3 is [14:12]
ex_alu_out  in  32  ALU c_out: address for LOAD/STORE, result otherwise
ex_rs2_data  in  32  store data
ex_rd  in  5  destination register
ex_rd_wr  in  1  ALU rd_wr
mem_req  out  1  data memory request
mem_we  out  1  1 = store
mem_addr  out  32  word-aligned address, equal to {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-steered store data
mem_rdata  in  32  read data, valid when mem_ready
mem_ready  in  1  memory completes the request this cycle
wb_valid  out  1  one-cycle pulse: result available
wb_data  out  32  writeback value
wb_rd  out  5  destination register
wb_wr  out  1  register-file write enable
wb_exc  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3
wb_exc_addr  out  32  faulting address; 0 when wb_exc = 00

Behaviour:
- Reset: state IDLE. All outputs 0 except ex_ready = 1. Reset in WAIT abandons the access: mem_req is 0 after the reset edge.
- States:
  - IDLE: ex_ready = 1.
  - WAIT: ex_ready = 0; a memory access is outstanding.
- Non-memory transfer (opcode not 0000011 or 0100011):
  - Next cycle: wb_valid = 1, wb_data = ex_alu_out, wb_rd = ex_rd, wb_wr = ex_rd_wr, wb_exc = 00.
  - Latency 1; the stage stays in IDLE, so back-to-back transfers run at 1 per cycle.
- LOAD/STORE transfer:
  - Decode width from funct3. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
  - Any other funct3: no request; next cycle wb_valid = 1, wb_wr = 0, wb_exc = 11.
  - Misaligned (half with addr[0] = 1, or word with addr[1:0] != 0): no request; next cycle wb_valid = 1, wb_wr = 0, wb_exc = 01, wb_exc_addr = address.
  - Otherwise: register the access and go to WAIT. From the next cycle mem_req = 1 with mem_we/addr/be/wdata held stable until mem_ready is sampled high.
- Byte enables:
  - Byte: 1 << addr[1:0].
  - Half: 0011 or 1100 selected by addr[1].
  - Word: 1111.
- Store data is replicated across lanes: byte {4{b}}, half {2{h}}.
- Completion in WAIT with mem_ready = 1:
  - Next cycle wb_valid = 1, mem_req = 0, state returns to IDLE.
  - Load: select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; wb_wr = ex_rd_wr as captured.
  - Store: wb_wr = 0, wb_data = 0.
  - Minimum memory-op latency: accept at cycle 0, mem_req at cycle 1, ready at cycle 1, wb_valid at cycle 2.
- Timeout:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches MEM_TIMEOUT without mem_ready: drop mem_req, go to IDLE, wb_valid = 1, wb_wr = 0, wb_exc = 10, wb_exc_addr = address.
  - mem_ready arriving on the same cycle the count reaches MEM_TIMEOUT completes normally; ready wins.
- Any mem_ready while mem_req = 0 is ignored.
- wb_rd is always driven with the captured rd.
- Loads to rd = 0 are passed through unchanged; the register file discards them.

Test Plan:
1. ADD result 0x0000_1234, rd = 5, rd_wr = 1 -> next cycle wb_valid = 1, wb_data = 0x1234, wb_rd = 5, wb_wr = 1; ex_ready stays 1.
2. LB addr 0x103, mem_rdata = 0x80AA_BBCC, ready 1 cycle after req -> mem_addr = 0x100, mem_be = 1000, wb_data = 0xFFFF_FF80; LBU gives 0x0000_0080.
3. SH addr 0x202, rs2 = 0xDEAD_BEEF -> mem_we = 1, mem_be = 1100, mem_wdata = 0xBEEF_BEEF, wb_wr = 0; ex_ready = 0 until completion.
4. LW addr 0x301 -> no mem_req, wb_exc = 01, wb_exc_addr = 0x301, wb_wr = 0; funct3 = 011 load -> wb_exc = 11.
5. MEM_TIMEOUT = 4, mem_ready held 0 -> after 4 WAIT cycles mem_req = 0, wb_exc = 10; repeat with ready on the 4th cycle -> normal completion.
6. rst asserted mid-WAIT with a load outstanding -> after the edge mem_req = 0, ex_ready = 1, wb_valid = 0; a later LW of 0x1122_3344 returns exactly 0x1122_3344.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding aligned load/store with lane steering,
// load extension, timeout and registered writeback result.
module mem_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [31:0]     ex_instr,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_rd_wr,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_wr,
  output logic [1:0]      wb_exc,
  output logic [XLEN-1:0] wb_exc_addr
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [1:0]      lane;
  logic            rd_wr_q;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic [1:0]      off;
  logic            is_load;
  logic            is_store;
  logic            f3_ok;
  logic            misal;
  logic [3:0]      be_n;
  logic [XLEN-1:0] wdata_n;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] ld_val;
  logic            unused_instr;

  assign unused_instr = ^{ex_instr[31:15], ex_instr[11:7]};

  // Decode of the presented instruction: legality, alignment, lane steering
  always_comb begin
    op       = ex_instr[6:0];
    f3       = ex_instr[14:12];
    off      = ex_alu_out[1:0];
    is_load  = (op == OP_LOAD);
    is_store = (op == OP_STORE);
    if (is_load)
      f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
              (f3 == 3'b100) || (f3 == 3'b101);
    else
      f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    misal   = 1'b0;
    be_n    = 4'hF;
    wdata_n = ex_rs2_data;
    case (f3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << off;
        wdata_n = {4{ex_rs2_data[7:0]}};
      end
      2'b01: begin
        misal   = off[0];
        be_n    = off[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{ex_rs2_data[15:0]}};
      end
      default: begin
        misal = (off != 2'b00);
      end
    endcase
  end

  // Lane select and sign/zero extension of returned load data
  always_comb begin
    rd_shift = mem_rdata >> {lane, 3'b000};
    case (f3_q)
      3'b000:  ld_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_val = {24'b0, rd_shift[7:0]};
      3'b101:  ld_val = {16'b0, rd_shift[15:0]};
      default: ld_val = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      f3_q        <= '0;
      lane        <= '0;
      rd_wr_q     <= 1'b0;
      ex_ready    <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_wr       <= 1'b0;
      wb_exc      <= 2'b00;
      wb_exc_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            wb_rd   <= ex_rd;
            f3_q    <= f3;
            lane    <= off;
            rd_wr_q <= ex_rd_wr;
            if (!is_load && !is_store) begin
              wb_valid    <= 1'b1;
              wb_data     <= ex_alu_out;
              wb_wr       <= ex_rd_wr;
              wb_exc      <= 2'b00;
              wb_exc_addr <= '0;
            end else if (!f3_ok || misal) begin
              wb_valid    <= 1'b1;
              wb_data     <= '0;
              wb_wr       <= 1'b0;
              wb_exc      <= f3_ok ? 2'b01 : 2'b11;
              wb_exc_addr <= ex_alu_out;
            end else begin
              state     <= S_WAIT;
              ex_ready  <= 1'b0;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {ex_alu_out[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
            end
          end
        end
        S_WAIT: begin
          // A ready on the final counted cycle still completes normally
          if (mem_ready) begin
            state       <= S_IDLE;
            ex_ready    <= 1'b1;
            mem_req     <= 1'b0;
            wb_valid    <= 1'b1;
            wb_data     <= mem_we ? '0 : ld_val;
            wb_wr       <= !mem_we && rd_wr_q;
            wb_exc      <= 2'b00;
            wb_exc_addr <= '0;
          end else if ((MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT - 1))) begin
            state       <= S_IDLE;
            ex_ready    <= 1'b1;
            mem_req     <= 1'b0;
            wb_valid    <= 1'b1;
            wb_data     <= '0;
            wb_wr       <= 1'b0;
            wb_exc      <= 2'b10;
            wb_exc_addr <= {mem_addr[31:2], lane};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random load/store/ALU traffic against a
// word-addressed memory model and spec-level expected results.
module tb_mem_stage;

  localparam int unsigned TMO = 4;
  localparam logic [6:0] LOAD  = 7'h03;
  localparam logic [6:0] STORE = 7'h23;
  localparam logic [6:0] ALU   = 7'h33;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_instr;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_rd_wr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_wr;
  logic [1:0]  wb_exc;
  logic [31:0] wb_exc_addr;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem [int unsigned];

  mem_stage #(.XLEN(32), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr),
    .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_rd_wr(ex_rd_wr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_wr(wb_wr),
    .wb_exc(wb_exc), .wb_exc_addr(wb_exc_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input int unsigned idx);
    if (mem.exists(idx)) return mem[idx];
    return (idx * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Checks the writeback pulse, then that it lasts one cycle with stray ready ignored
  task automatic check_wb(input logic [31:0] d, input logic chk_d, input logic [4:0] rd,
                          input logic wr, input logic [1:0] exc, input logic [31:0] ea,
                          input logic chk_ea);
    chk("wb_valid", 32'(wb_valid), 32'd1);
    if (chk_d) chk("wb_data", wb_data, d);
    chk("wb_rd", 32'(wb_rd), 32'(rd));
    chk("wb_wr", 32'(wb_wr), 32'(wr));
    chk("wb_exc", 32'(wb_exc), 32'(exc));
    if (chk_ea) chk("wb_exc_addr", wb_exc_addr, ea);
    chk("mem_req_after", 32'(mem_req), 32'd0);
    chk("ex_ready_after", 32'(ex_ready), 32'd1);
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("wb_pulse", 32'(wb_valid), 32'd0);
    chk("mem_req_idle", 32'(mem_req), 32'd0);
  endtask

  // One instruction; lat = WAIT cycles with ready low before ready is raised
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic wr,
                        input int lat);
    logic [31:0] instr, word, wd, v, m;
    logic [3:0]  be;
    logic        is_ld, is_st, legal, misal, done, r;
    int          size;
    int unsigned idx;
    instr = $urandom;
    instr[6:0] = op;
    instr[14:12] = f3;
    is_ld = (op == LOAD);
    is_st = (op == STORE);
    legal = is_ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    size  = 1 << f3[1:0];
    misal = (a % 32'(size)) != 0;

    @(negedge clk);
    chk("ex_ready_idle", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; ex_instr = instr; ex_alu_out = a; ex_rs2_data = rs2;
    ex_rd = rd; ex_rd_wr = wr;
    @(posedge clk); #1;
    ex_valid = 1'b0;

    if (!is_ld && !is_st) begin
      check_wb(a, 1'b1, rd, wr, 2'b00, 32'h0, 1'b1);
    end else if (!legal) begin
      chk("no_req_illegal", 32'(mem_req), 32'd0);
      check_wb(32'h0, 1'b0, rd, 1'b0, 2'b11, a, 1'b0);
    end else if (misal) begin
      chk("no_req_misal", 32'(mem_req), 32'd0);
      check_wb(32'h0, 1'b0, rd, 1'b0, 2'b01, a, 1'b1);
    end else begin
      be   = 4'(((1 << size) - 1) << a[1:0]);
      wd   = (size == 1) ? (rs2 & 32'hFF) * 32'h0101_0101 :
             (size == 2) ? (rs2 & 32'hFFFF) * 32'h0001_0001 : rs2;
      idx  = a >> 2;
      word = mem_rd(idx);
      done = 1'b0;
      for (int k = 1; k <= int'(TMO) && !done; k++) begin
        chk("mem_req_wait", 32'(mem_req), 32'd1);
        chk("ex_ready_wait", 32'(ex_ready), 32'd0);
        chk("mem_we", 32'(mem_we), 32'(is_st));
        chk("mem_addr", mem_addr, a & ~32'h3);
        chk("mem_be", 32'(mem_be), 32'(be));
        if (is_st) chk("mem_wdata", mem_wdata, wd);
        r = (k == lat + 1);
        mem_ready = r;
        mem_rdata = is_ld ? word : $urandom;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        done = r;
      end
      if (!done) begin
        check_wb(32'h0, 1'b0, rd, 1'b0, 2'b10, a, 1'b1);
      end else if (is_st) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
        mem[idx] = word;
        check_wb(32'h0, 1'b1, rd, 1'b0, 2'b00, 32'h0, 1'b1);
      end else begin
        m = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
        v = (word >> (8 * a[1:0])) & m;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~m;
        check_wb(v, 1'b1, rd, wr, 2'b00, 32'h0, 1'b1);
      end
    end
  endtask

  initial begin
    logic [6:0]  op;
    logic [31:0] a;
    int          sel;
    rst = 1'b1; ex_valid = 1'b0; ex_instr = '0; ex_alu_out = '0; ex_rs2_data = '0;
    ex_rd = '0; ex_rd_wr = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_exc", 32'(wb_exc), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    rst = 1'b0;

    // Directed plan items
    run_op(ALU, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 0);
    run_op(ALU, 3'd0, 32'hCAFE_0001, 32'h0, 5'd6, 1'b0, 0);
    mem[32'h100 >> 2] = 32'h80AA_BBCC;
    run_op(LOAD, 3'd0, 32'h103, 32'h0, 5'd7, 1'b1, 1);
    run_op(LOAD, 3'd4, 32'h103, 32'h0, 5'd7, 1'b1, 0);
    run_op(LOAD, 3'd1, 32'h102, 32'h0, 5'd8, 1'b1, 2);
    run_op(STORE, 3'd1, 32'h202, 32'hDEAD_BEEF, 5'd9, 1'b1, 1);
    run_op(LOAD, 3'd2, 32'h200, 32'h0, 5'd10, 1'b1, 0);
    run_op(LOAD, 3'd2, 32'h301, 32'h0, 5'd11, 1'b1, 0);
    run_op(LOAD, 3'd3, 32'h300, 32'h0, 5'd11, 1'b1, 0);
    run_op(STORE, 3'd4, 32'h300, 32'h0, 5'd11, 1'b1, 0);
    run_op(LOAD, 3'd2, 32'h400, 32'h0, 5'd12, 1'b1, 4);
    run_op(LOAD, 3'd2, 32'h404, 32'h0, 5'd12, 1'b1, 3);
    run_op(STORE, 3'd2, 32'h408, 32'h1357_9BDF, 5'd0, 1'b1, 4);

    // Reset while a load is outstanding
    @(negedge clk);
    ex_valid = 1'b1; ex_instr = {17'h0, 3'd2, 5'd1, LOAD}; ex_alu_out = 32'h600;
    ex_rd = 5'd3; ex_rd_wr = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rstw_req_before", 32'(mem_req), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_mem_req", 32'(mem_req), 32'd0);
    chk("rstw_ex_ready", 32'(ex_ready), 32'd1);
    chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
    mem[32'h500 >> 2] = 32'h1122_3344;
    run_op(LOAD, 3'd2, 32'h500, 32'h0, 5'd4, 1'b1, 0);

    // Random traffic over a small address window so loads revisit stores
    for (int n = 0; n < 120; n++) begin
      sel = $urandom_range(0, 9);
      a = 32'h800 + $urandom_range(0, 63);
      if (sel < 3) begin
        op = 7'($urandom);
        if (op == LOAD || op == STORE) op = ALU;
        a = $urandom;
      end else begin
        op = (sel < 7) ? LOAD : STORE;
      end
      run_op(op, 3'($urandom_range(0, 7)), a, $urandom, 5'($urandom), 1'($urandom),
             $urandom_range(0, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
